// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI slave used to exercise an SPI master in any CPOL/CPHA mode.
// Define SPI_SLAVE_RESPONDER_ECHO_EN to send back, in each word slot after the first, the word received in the previous slot.
module spi_slave_responder #(
    parameter int DATA_WIDTH       = 32,
    parameter int SYNC_STAGES      = 2,
    parameter int WORD_COUNT_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        serial_clock,
    input  logic                        chip_select,
    input  logic                        serial_in,
    input  logic                        clock_polarity,
    input  logic                        clock_phase,
    input  logic [DATA_WIDTH-1:0]       tx_data,
    output logic                        serial_out,
    output logic [DATA_WIDTH-1:0]       rx_data,
    output logic                        rx_valid,
    output logic                        frame_active,
    output logic                        frame_aborted,
    output logic [WORD_COUNT_WIDTH-1:0] word_count
);

    localparam int BIT_COUNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [BIT_COUNT_WIDTH-1:0] LAST_BIT =
        BIT_COUNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   sdi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   sample_edge;
    logic                   shift_edge;

    logic [0:0]             state;
    logic                   latched_cpol;
    logic                   latched_cpha;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic                   tx_bit;
    logic                   reload_pending;
    logic                   skip_shift;
    logic [BIT_COUNT_WIDTH-1:0] bit_count;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_next;
    logic [DATA_WIDTH-1:0]  reload_word;

    // Bring the asynchronous SPI pins into the clock domain and keep one extra SCLK/CS sample for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sdi_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], serial_clock};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_select};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], serial_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // Modes 0 and 3 sample on the rising edge; modes 1 and 2 on the falling edge.
    assign sample_edge = (latched_cpol == latched_cpha) ? sclk_rise : sclk_fall;
    assign shift_edge  = (latched_cpol == latched_cpha) ? sclk_fall : sclk_rise;

    assign rx_next = {rx_shift, sdi_s};

`ifdef SPI_SLAVE_RESPONDER_ECHO_EN
    // At the reload point rx_data already holds the word that just finished.
    assign reload_word = rx_data;
`else
    assign reload_word = tx_data;
`endif

    // Frame sequencing, serial shifting and the word-level outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= STATE_IDLE;
            latched_cpol   <= 1'b0;
            latched_cpha   <= 1'b0;
            tx_shift       <= '0;
            tx_bit         <= 1'b0;
            reload_pending <= 1'b0;
            skip_shift     <= 1'b1;
            bit_count      <= '0;
            rx_shift       <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            frame_aborted  <= 1'b0;
            word_count     <= '0;
        end else begin
            rx_valid      <= 1'b0;
            frame_aborted <= 1'b0;
            unique case (state)
                STATE_IDLE: begin
                    if (cs_fall) begin
                        state          <= STATE_ACTIVE;
                        latched_cpol   <= clock_polarity;
                        latched_cpha   <= clock_phase;
                        tx_bit         <= tx_data[DATA_WIDTH-1];
                        tx_shift       <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                        reload_pending <= 1'b0;
                        skip_shift     <= clock_phase;
                        bit_count      <= '0;
                        word_count     <= '0;
                    end
                end
                STATE_ACTIVE: begin
                    // Deselect beats any SCLK edge seen in the same cycle.
                    if (cs_s) begin
                        state     <= STATE_IDLE;
                        bit_count <= '0;
                        if (bit_count != '0) begin
                            frame_aborted <= 1'b1;
                        end
                    end else if (sample_edge) begin
                        rx_shift <= rx_next[DATA_WIDTH-2:0];
                        if (bit_count == LAST_BIT) begin
                            bit_count      <= '0;
                            rx_data        <= rx_next;
                            rx_valid       <= 1'b1;
                            reload_pending <= 1'b1;
                            if (word_count != '1) begin
                                word_count <= word_count
                                    + WORD_COUNT_WIDTH'(1);
                            end
                        end else begin
                            bit_count <= bit_count + BIT_COUNT_WIDTH'(1);
                        end
                    end else if (shift_edge) begin
                        if (skip_shift) begin
                            // CPHA=1 leading edge: MSB is already on the line.
                            skip_shift <= 1'b0;
                        end else if (reload_pending) begin
                            // Fetch the next word as late as possible so tx_data can change after rx_valid.
                            reload_pending <= 1'b0;
                            tx_bit   <= reload_word[DATA_WIDTH-1];
                            tx_shift <= {reload_word[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            tx_bit   <= tx_shift[DATA_WIDTH-1];
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    assign frame_active = (state == STATE_ACTIVE);

    // MISO follows the raw select pin so the line releases immediately.
    assign serial_out = chip_select ? 1'bz : tx_bit;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: acts as SPI master in all four modes and checks the slave
// against a word-level model (events land SYNC_STAGES+1 clocks after the pin change).
module tb_spi_slave_responder;

    localparam int DW  = 16;
    localparam int NS  = 2;
    localparam int WCW = 2;
    localparam int LAT = NS + 1;
    localparam int H   = 8;
    localparam int EV_START = 0;
    localparam int EV_WORD  = 1;
    localparam int EV_END   = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           serial_clock;
    logic           chip_select;
    logic           serial_in;
    logic           clock_polarity;
    logic           clock_phase;
    logic [DW-1:0]  tx_data;
    wire            serial_out;
    logic [DW-1:0]  rx_data;
    logic           rx_valid;
    logic           frame_active;
    logic           frame_aborted;
    logic [WCW-1:0] word_count;

    spi_slave_responder #(
        .DATA_WIDTH(DW),
        .SYNC_STAGES(NS),
        .WORD_COUNT_WIDTH(WCW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .serial_clock(serial_clock),
        .chip_select(chip_select),
        .serial_in(serial_in),
        .clock_polarity(clock_polarity),
        .clock_phase(clock_phase),
        .tx_data(tx_data),
        .serial_out(serial_out),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_active(frame_active),
        .frame_aborted(frame_aborted),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            at;
        int            kind;
        logic [DW-1:0] data;
        logic          partial;
    } ev_t;

    ev_t           evq[$];
    ev_t           m_ev;
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            rv_cnt = 0;
    int            ab_cnt = 0;
    logic          m_active = 1'b0;
    logic [DW-1:0] m_rx = '0;
    int            m_wc = 0;
    logic          m_valid;
    logic          m_abort;
    logic [DW-1:0] tx_w[8];
    logic [DW-1:0] mosi_w[8];
    logic [DW-1:0] rd_w[8];

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic sched(input int kind, input logic [DW-1:0] data,
                         input logic partial);
        ev_t e;
        e.at = cyc + LAT;
        e.kind = kind;
        e.data = data;
        e.partial = partial;
        evq.push_back(e);
    endtask

    // Word-level model and per-cycle output comparison.
    always @(posedge clock) begin
        #1;
        m_valid = 1'b0;
        m_abort = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_rx = '0;
            m_wc = 0;
            evq.delete();
        end else begin
            while (evq.size() > 0 && evq[0].at <= cyc) begin
                m_ev = evq.pop_front();
                case (m_ev.kind)
                    EV_START: begin
                        m_active = 1'b1;
                        m_wc = 0;
                    end
                    EV_WORD: begin
                        m_valid = 1'b1;
                        m_rx = m_ev.data;
                        if (m_wc < (1 << WCW) - 1) m_wc = m_wc + 1;
                    end
                    default: begin
                        m_active = 1'b0;
                        m_abort = m_ev.partial;
                    end
                endcase
            end
        end
        if (rx_valid === 1'b1) rv_cnt++;
        if (frame_aborted === 1'b1) ab_cnt++;
        check("rx_valid", 64'(rx_valid), 64'(m_valid));
        check("rx_data", 64'(rx_data), 64'(m_rx));
        check("word_count", 64'(word_count), 64'(m_wc));
        check("frame_active", 64'(frame_active), 64'(m_active));
        check("frame_aborted", 64'(frame_aborted), 64'(m_abort));
        check("miso_z", 64'(serial_out === 1'bz), 64'(chip_select));
    end

    function automatic logic [DW-1:0] exp_read(input int w);
`ifdef SPI_SLAVE_RESPONDER_ECHO_EN
        return (w == 0) ? tx_w[0] : mosi_w[w-1];
`else
        return tx_w[w];
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic idle_mode(input logic cpol, input logic cpha);
        clock_polarity = cpol;
        clock_phase = cpha;
        serial_clock = cpol;
        tick(H);
    endtask

    task automatic run_frame(input logic cpol, input logic cpha,
                             input int nbits, input bit end_reset);
        logic [DW-1:0] rd;
        logic [DW-1:0] mask;
        int w;
        int b;
        int k;
        idle_mode(cpol, cpha);
        tx_data = tx_w[0];
        rd = '0;
        chip_select = 1'b0;
        sched(EV_START, '0, 1'b0);
        tick(H);
        // mode pins move mid-frame; the slave must keep the latched mode
        clock_polarity = ~cpol;
        clock_phase = ~cpha;
        for (int i = 0; i < nbits; i++) begin
            w = i / DW;
            b = DW - 1 - (i % DW);
            if (cpha) begin
                serial_clock = ~serial_clock;
                serial_in = mosi_w[w][b];
            end else begin
                serial_in = mosi_w[w][b];
            end
            tick(H);
            rd[b] = serial_out;
            serial_clock = ~serial_clock;
            if (b == 0) begin
                sched(EV_WORD, mosi_w[w], 1'b0);
                rd_w[w] = rd;
                check("miso_word", 64'(rd), 64'(exp_read(w)));
                tick(LAT + 1);
                tx_data = tx_w[w + 1];
                tick(H - LAT - 1);
            end else begin
                tick(H);
            end
            if (!cpha) serial_clock = ~serial_clock;
        end
        tick(H);
        k = nbits % DW;
        if (k != 0) begin
            mask = ~({DW{1'b1}} >> k);
            check("miso_partial", 64'(rd & mask),
                  64'(exp_read(nbits / DW) & mask));
        end
        if (end_reset) begin
            reset = 1'b1;
            tick(1);
            check("rst_rx_data", 64'(rx_data), 64'(0));
            check("rst_word_count", 64'(word_count), 64'(0));
            check("rst_frame_active", 64'(frame_active), 64'(0));
            check("rst_rx_valid", 64'(rx_valid), 64'(0));
            check("rst_miso_bit", 64'(serial_out === 1'b0), 64'(1));
            tick(1);
            reset = 1'b0;
            tick(2);
            chip_select = 1'b1;
            tick(H);
        end else begin
            chip_select = 1'b1;
            sched(EV_END, '0, k != 0);
            tick(H);
        end
    endtask

    int rv0;
    int ab0;

    initial begin
        reset = 1'b1;
        serial_clock = 1'b0;
        chip_select = 1'b1;
        serial_in = 1'b0;
        clock_polarity = 1'b0;
        clock_phase = 1'b0;
        tx_data = '0;
        for (int i = 0; i < 8; i++) begin
            tx_w[i] = '0;
            mosi_w[i] = '0;
            rd_w[i] = '0;
        end
        tick(4);
        check("reset_rx_data", 64'(rx_data), 64'(0));
        check("reset_word_count", 64'(word_count), 64'(0));
        check("reset_frame_active", 64'(frame_active), 64'(0));
        check("reset_miso_z", 64'(serial_out === 1'bz), 64'(1));
        reset = 1'b0;
        tick(4);

        // mode 0, single word
        rv0 = rv_cnt;
        ab0 = ab_cnt;
        tx_w[0] = 16'hACDC;
        mosi_w[0] = 16'h1234;
        run_frame(1'b0, 1'b0, 16, 1'b0);
        check("m0_read", 64'(rd_w[0]), 64'h0000_0000_0000_ACDC);
        check("m0_rx_data", 64'(rx_data), 64'h1234);
        check("m0_word_count", 64'(word_count), 64'd1);
        check("m0_valid_pulses", 64'(rv_cnt - rv0), 64'd1);
        check("m0_no_abort", 64'(ab_cnt - ab0), 64'd0);

        // mode 3, single word, MISO released outside the frame
        check("m3_z_before", 64'(serial_out === 1'bz), 64'd1);
        tx_w[0] = 16'hA5C3;
        mosi_w[0] = 16'h3C96;
        run_frame(1'b1, 1'b1, 16, 1'b0);
        check("m3_z_after", 64'(serial_out === 1'bz), 64'd1);
        check("m3_read", 64'(rd_w[0]), 64'hA5C3);
        check("m3_rx_data", 64'(rx_data), 64'h3C96);

        // mode 1, two words, tx_data changed after the first rx_valid
        rv0 = rv_cnt;
        tx_w[0] = 16'hCAFE;
        tx_w[1] = 16'h5555;
        mosi_w[0] = 16'hBEEF;
        mosi_w[1] = 16'h0001;
        run_frame(1'b0, 1'b1, 32, 1'b0);
        check("m1_read0", 64'(rd_w[0]), 64'hCAFE);
`ifdef SPI_SLAVE_RESPONDER_ECHO_EN
        check("m1_read1", 64'(rd_w[1]), 64'hBEEF);
`else
        check("m1_read1", 64'(rd_w[1]), 64'h5555);
`endif
        check("m1_word_count", 64'(word_count), 64'd2);
        check("m1_valid_pulses", 64'(rv_cnt - rv0), 64'd2);
        check("m1_rx_data", 64'(rx_data), 64'h0001);

        // mode 2, abort after 5 bits, then a full frame
        rv0 = rv_cnt;
        ab0 = ab_cnt;
        tx_w[0] = 16'h9F00;
        mosi_w[0] = 16'hF800;
        run_frame(1'b1, 1'b0, 5, 1'b0);
        check("m2_abort_pulses", 64'(ab_cnt - ab0), 64'd1);
        check("m2_abort_no_valid", 64'(rv_cnt - rv0), 64'd0);
        check("m2_abort_rx_kept", 64'(rx_data), 64'h0001);
        tx_w[0] = 16'h1357;
        mosi_w[0] = 16'h2468;
        run_frame(1'b1, 1'b0, 16, 1'b0);
        check("m2_read", 64'(rd_w[0]), 64'h1357);
        check("m2_rx_data", 64'(rx_data), 64'h2468);

        // mode 0, five words: counter saturates, echo path exercised
        for (int i = 0; i < 5; i++) begin
            mosi_w[i] = 16'(16'h0011 * (i + 1));
            tx_w[i] = 16'(16'h00A1 + i);
        end
        run_frame(1'b0, 1'b0, 80, 1'b0);
        check("sat_word_count", 64'(word_count), 64'd3);
        check("sat_rx_data", 64'(rx_data), 64'h0055);
`ifdef SPI_SLAVE_RESPONDER_ECHO_EN
        check("echo_read1", 64'(rd_w[1]), 64'h0011);
        check("echo_read2", 64'(rd_w[2]), 64'h0022);
`else
        check("tx_read1", 64'(rd_w[1]), 64'h00A2);
        check("tx_read2", 64'(rd_w[2]), 64'h00A3);
`endif

        // mode 0, reset after 10 bits, then a fresh frame
        tx_w[0] = 16'h6789;
        mosi_w[0] = 16'hFFFF;
        run_frame(1'b0, 1'b0, 10, 1'b1);
        tx_w[0] = 16'h0F0F;
        mosi_w[0] = 16'hF0F0;
        run_frame(1'b0, 1'b0, 16, 1'b0);
        check("post_rst_read", 64'(rd_w[0]), 64'h0F0F);
        check("post_rst_rx_data", 64'(rx_data), 64'hF0F0);
        check("post_rst_word_count", 64'(word_count), 64'd1);

        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
